board_game_core: RTL and testbench

// - Parametrised successor of the 3x3 tic-tac-toe game engine: NxN board, K-in-a-row win.
// - Accepts moves over a valid/ready handshake, validates them, alternates players,

---
 rtl/board_game_core.sv | 277 +++++++++++++++++++++++++++
 tb/tb_board_game_core.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_game_core.sv
// board_game_core: NxN board, K-in-a-row game engine with a sequential win/draw line walker.
// Latency: a legal move is accepted at edge E, and its result is posted at edge E+8*(WIN_LEN-1).
// Backpressure: o_move_ready drops while a move is being checked and after the game ends.
//
// Ports:
//   i_clock, i_reset          clock and synchronous active-high reset
//   i_new_game                clears the board; X moves next. Has priority over a move
//   i_move_valid/x/y          move request; it is taken when i_move_valid & o_move_ready
//   o_move_ready              engine is idle and can take a move
//   o_move_error              one-cycle pulse after a rejected move (off board, or cell occupied)
//   o_turn                    player to move: 0 = X, 1 = O
//   o_winner, o_game_over     00 none, 01 X, 10 O, 11 draw; game_over = winner != 00
//   o_move_count              stones placed in the current game
//   o_board                   cell (x,y) at [2*(y*N+x)+:2]: 00 empty, 01 X, 10 O
//   o_score_x/o/draw          match tallies; built only when SCOREBOARD_EN is defined, otherwise 0
module board_game_core #(
  parameter int BOARD_N = 3,
  parameter int WIN_LEN = 3,
  localparam int CW = $clog2(BOARD_N),
  localparam int MW = $clog2(BOARD_N * BOARD_N + 1)
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_new_game,
  input  logic                           i_move_valid,
  input  logic [CW-1:0]                  i_move_x,
  input  logic [CW-1:0]                  i_move_y,
  output logic                           o_move_ready,
  output logic                           o_move_error,
  output logic                           o_turn,
  output logic [1:0]                     o_winner,
  output logic                           o_game_over,
  output logic [MW-1:0]                  o_move_count,
  output logic [2*BOARD_N*BOARD_N-1:0]   o_board,
  output logic [7:0]                     o_score_x,
  output logic [7:0]                     o_score_o,
  output logic [7:0]                     o_score_draw
);

  localparam int NC = BOARD_N * BOARD_N;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DONE} state_t;

  // Unit step per direction, in walk order: H, V, diagonal, anti-diagonal.
  function automatic logic signed [4:0] f_dx(input logic [1:0] d);
    f_dx = (d == 2'd1) ? 5'sd0 : 5'sd1;
  endfunction

  function automatic logic signed [4:0] f_dy(input logic [1:0] d);
    case (d)
      2'd0:    f_dy = 5'sd0;
      2'd3:    f_dy = -5'sd1;
      default: f_dy = 5'sd1;
    endcase
  endfunction

  state_t                r_state;
  logic                  r_ready;
  logic                  r_error;
  logic                  r_turn;
  logic [1:0]            r_winner;
  logic                  r_over;
  logic [MW-1:0]         r_count;
  logic [2*NC-1:0]       r_board;

  // Line-walker state. Coordinates are 5-bit signed, so stepping off any edge
  // gives a negative value or a value >= BOARD_N. It never wraps back onto the board.
  logic signed [4:0]     r_mx, r_my;     // cell of the move under check
  logic signed [4:0]     r_px, r_py;     // cell examined this cycle
  logic [1:0]            r_dir;
  logic                  r_back;         // 0: forward sub-walk, 1: backward
  logic [3:0]            r_step;         // step index inside the sub-walk
  logic [4:0]            r_cnt;          // run length for the current direction
  logic                  r_streak;       // sub-walk still unbroken
  logic                  r_win;          // some earlier direction already reached WIN_LEN

  logic                  w_move_oob;
  int                    w_move_idx;
  logic [1:0]            w_move_cell;
  logic                  w_reject;
  logic [1:0]            w_mover;
  logic signed [4:0]     w_in_x, w_in_y;
  logic                  w_inb;
  int                    w_probe_idx;
  logic [1:0]            w_probe_cell;
  logic                  w_hit;
  logic [4:0]            w_cnt_nxt;
  logic                  w_last_sub;
  logic                  w_dir_win;
  logic                  w_final;
  logic                  w_any_win;
  logic                  w_full;
  logic signed [4:0]     w_dx, w_dy, w_sdx, w_sdy, w_ndx, w_ndy;

  assign w_in_x  = 5'(i_move_x);
  assign w_in_y  = 5'(i_move_y);
  assign w_mover = {r_turn, ~r_turn};

  always_comb begin
    w_move_oob  = (int'(i_move_x) >= BOARD_N) || (int'(i_move_y) >= BOARD_N);
    w_move_idx  = int'(i_move_y) * BOARD_N + int'(i_move_x);
    w_move_cell = 2'b00;
    for (int i = 0; i < NC; i++) begin
      if (i == w_move_idx) w_move_cell = r_board[2*i +: 2];
    end
    // An off-board index can alias a real cell, so the range test must dominate.
    w_reject = w_move_oob || (w_move_cell != 2'b00);

    w_inb = (r_px >= 5'sd0) && (int'(r_px) < BOARD_N) &&
            (r_py >= 5'sd0) && (int'(r_py) < BOARD_N);
    w_probe_idx  = int'(r_py) * BOARD_N + int'(r_px);
    w_probe_cell = 2'b00;
    for (int i = 0; i < NC; i++) begin
      if (w_inb && (i == w_probe_idx)) w_probe_cell = r_board[2*i +: 2];
    end

    w_hit      = r_streak && w_inb && (w_probe_cell == w_mover);
    w_cnt_nxt  = r_cnt + {4'd0, w_hit};
    w_last_sub = (int'(r_step) == WIN_LEN - 2);
    w_dir_win  = (int'(w_cnt_nxt) >= WIN_LEN);
    w_final    = (r_state == S_CHECK) && w_last_sub && r_back && (r_dir == 2'd3);
    w_any_win  = r_win || w_dir_win;
    w_full     = (int'(r_count) == NC);

    w_dx  = f_dx(r_dir);
    w_dy  = f_dy(r_dir);
    w_sdx = r_back ? -w_dx : w_dx;
    w_sdy = r_back ? -w_dy : w_dy;
    w_ndx = f_dx(r_dir + 2'd1);
    w_ndy = f_dy(r_dir + 2'd1);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset || i_new_game) begin
      // new_game clears exactly what reset clears, except the score tallies.
      r_state  <= S_IDLE;
      r_ready  <= 1'b1;
      r_error  <= 1'b0;
      r_turn   <= 1'b0;
      r_winner <= 2'b00;
      r_over   <= 1'b0;
      r_count  <= '0;
      r_board  <= '0;
      r_mx     <= '0;
      r_my     <= '0;
      r_px     <= '0;
      r_py     <= '0;
      r_dir    <= 2'd0;
      r_back   <= 1'b0;
      r_step   <= 4'd0;
      r_cnt    <= 5'd1;
      r_streak <= 1'b1;
      r_win    <= 1'b0;
    end else begin
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_move_valid) begin
            if (w_reject) begin
              r_error <= 1'b1;
            end else begin
              for (int i = 0; i < NC; i++) begin
                if (i == w_move_idx) r_board[2*i +: 2] <= w_mover;
              end
              r_count  <= r_count + MW'(1);
              r_mx     <= w_in_x;
              r_my     <= w_in_y;
              r_px     <= w_in_x + 5'sd1;   // first probe: H direction, forward
              r_py     <= w_in_y;
              r_dir    <= 2'd0;
              r_back   <= 1'b0;
              r_step   <= 4'd0;
              r_cnt    <= 5'd1;
              r_streak <= 1'b1;
              r_win    <= 1'b0;
              r_state  <= S_CHECK;
              r_ready  <= 1'b0;
            end
          end
        end

        S_CHECK: begin
          if (!w_last_sub) begin
            r_step   <= r_step + 4'd1;
            r_streak <= w_hit;
            r_cnt    <= w_cnt_nxt;
            r_px     <= r_px + w_sdx;
            r_py     <= r_py + w_sdy;
          end else if (!r_back) begin
            // Forward sub-walk done: restart one step behind the move cell.
            r_back   <= 1'b1;
            r_step   <= 4'd0;
            r_streak <= 1'b1;
            r_cnt    <= w_cnt_nxt;
            r_px     <= r_mx - w_dx;
            r_py     <= r_my - w_dy;
          end else if (r_dir != 2'd3) begin
            r_win    <= w_any_win;
            r_dir    <= r_dir + 2'd1;
            r_back   <= 1'b0;
            r_step   <= 4'd0;
            r_streak <= 1'b1;
            r_cnt    <= 5'd1;
            r_px     <= r_mx + w_ndx;
            r_py     <= r_my + w_ndy;
          end else begin
            // Last probe of the anti-diagonal: post the result.
            r_win <= w_any_win;
            if (w_any_win) begin
              r_winner <= w_mover;
              r_over   <= 1'b1;
              r_state  <= S_DONE;
            end else if (w_full) begin
              r_winner <= 2'b11;
              r_over   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_turn  <= ~r_turn;
              r_state <= S_IDLE;
              r_ready <= 1'b1;
            end
          end
        end

        S_DONE: begin
          // Held here until new_game. Moves are not acknowledged.
          r_ready <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_move_ready = r_ready;
  assign o_move_error = r_error;
  assign o_turn       = r_turn;
  assign o_winner     = r_winner;
  assign o_game_over  = r_over;
  assign o_move_count = r_count;
  assign o_board      = r_board;

`ifdef SCOREBOARD_EN
  logic [7:0] r_score_x, r_score_o, r_score_draw;
  logic       w_post;

  // The posting edge is cancelled if new_game wins the same edge.
  assign w_post = w_final && !i_new_game;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_score_x    <= 8'd0;
      r_score_o    <= 8'd0;
      r_score_draw <= 8'd0;
    end else if (w_post) begin
      if (w_any_win && !r_turn && (r_score_x != 8'hFF))
        r_score_x <= r_score_x + 8'd1;
      if (w_any_win && r_turn && (r_score_o != 8'hFF))
        r_score_o <= r_score_o + 8'd1;
      if (!w_any_win && w_full && (r_score_draw != 8'hFF))
        r_score_draw <= r_score_draw + 8'd1;
    end
  end

  assign o_score_x    = r_score_x;
  assign o_score_o    = r_score_o;
  assign o_score_draw = r_score_draw;
`else
  assign o_score_x    = 8'd0;
  assign o_score_o    = 8'd0;
  assign o_score_draw = 8'd0;
`endif

endmodule

// File: tb/tb_board_game_core.sv
// Bench for board_game_core. It uses a 3x3/3 instance for the game tables and a 5x5/4
// instance for the anti-diagonal case. Expected values are hand-computed.
module tb_board_game_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       ng3, ng5, v3, v5;
  logic [2:0] mx, my;

  logic       r3, e3, t3, over3;
  logic [1:0] w3;
  logic [3:0] c3;
  logic [17:0] b3;
  logic [7:0] sx3, so3, sd3;

  logic       r5, e5, t5, over5;
  logic [1:0] w5;
  logic [4:0] c5;
  logic [49:0] b5;
  logic [7:0] sx5, so5, sd5;

  board_game_core #(.BOARD_N(3), .WIN_LEN(3)) dut (
    .i_clock(clk), .i_reset(rst), .i_new_game(ng3), .i_move_valid(v3),
    .i_move_x(mx[1:0]), .i_move_y(my[1:0]),
    .o_move_ready(r3), .o_move_error(e3), .o_turn(t3), .o_winner(w3),
    .o_game_over(over3), .o_move_count(c3), .o_board(b3),
    .o_score_x(sx3), .o_score_o(so3), .o_score_draw(sd3)
  );

  board_game_core #(.BOARD_N(5), .WIN_LEN(4)) dut5 (
    .i_clock(clk), .i_reset(rst), .i_new_game(ng5), .i_move_valid(v5),
    .i_move_x(mx), .i_move_y(my),
    .o_move_ready(r5), .o_move_error(e5), .o_turn(t5), .o_winner(w5),
    .o_game_over(over5), .o_move_count(c5), .o_board(b5),
    .o_score_x(sx5), .o_score_o(so5), .o_score_draw(sd5)
  );

  // sel picks the instance that do_move/pulse_ng drive and observe.
  bit         sel = 1'b0;
  logic       m_rdy, m_err, m_trn, m_over;
  logic [1:0] m_win;
  logic [4:0] m_cnt;
  assign m_rdy  = sel ? r5 : r3;
  assign m_err  = sel ? e5 : e3;
  assign m_trn  = sel ? t5 : t3;
  assign m_over = sel ? over5 : over3;
  assign m_win  = sel ? w5 : w3;
  assign m_cnt  = sel ? c5 : {1'b0, c3};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_ng();
    @(negedge clk);
    if (sel) ng5 = 1'b1; else ng3 = 1'b1;
    @(negedge clk);
    ng3 = 1'b0;
    ng5 = 1'b0;
  endtask

  // Presents one move, records the error pulse, and counts busy cycles until idle or game over.
  task automatic do_move(input int x, input int y, output logic err, output int lat);
    int n;
    n = 0;
    while (!m_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!m_rdy) chk("ready_timeout", {63'd0, m_rdy}, 64'd1);
    mx = 3'(x);
    my = 3'(y);
    if (sel) v5 = 1'b1; else v3 = 1'b1;
    @(negedge clk);
    v3 = 1'b0;
    v5 = 1'b0;
    err = m_err;
    lat = 0;
    while (!m_rdy && !m_over && lat < 100) begin
      lat++;
      @(negedge clk);
    end
    if (lat >= 100) chk("settle_timeout", 64'd0, 64'd1);
  endtask

  typedef struct {
    bit ng;     // pulse new_game before this move
    int x;
    int y;
    bit err;
    int win;
    bit trn;
    int cnt;
    int brd;    // expected board, or -1 to skip
  } vec_t;

  vec_t vq[$];

  task automatic add(input bit ng, input int x, input int y, input bit e,
                     input int w, input bit t, input int c, input int b);
    vec_t v;
    v = '{ng, x, y, e, w, t, c, b};
    vq.push_back(v);
  endtask

  logic err;
  int   lat;
  int   exp_sx, exp_so, exp_sd;
  int   xs5[8] = '{0, 0, 1, 1, 2, 2, 4, 3};
  int   ys5[8] = '{0, 3, 0, 2, 0, 1, 4, 0};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ng3 = 1'b0; ng5 = 1'b0; v3 = 1'b0; v5 = 1'b0; mx = 3'd0; my = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_ready", {63'd0, r3}, 64'd1);
    chk("rst_error", {63'd0, e3}, 64'd0);
    chk("rst_turn", {63'd0, t3}, 64'd0);
    chk("rst_winner", {62'd0, w3}, 64'd0);
    chk("rst_over", {63'd0, over3}, 64'd0);
    chk("rst_count", {60'd0, c3}, 64'd0);
    chk("rst_board", {46'd0, b3}, 64'd0);
    chk("rst_score_x", {56'd0, sx3}, 64'd0);
    chk("rst_score_d", {56'd0, sd3}, 64'd0);
    chk("rst_ready5", {63'd0, r5}, 64'd1);

    // Errors: occupied cell and off-board column leave board/turn/count alone.
    add(1, 1, 1, 0, 0, 1, 1, 256);
    add(0, 1, 1, 1, 0, 1, 1, 256);
    add(0, 3, 0, 1, 0, 1, 1, 256);
    add(0, 0, 0, 0, 0, 0, 2, 258);
    // Full board with no line: draw.
    add(1, 0, 0, 0, 0, 1, 1, -1);
    add(0, 1, 0, 0, 0, 0, 2, -1);
    add(0, 2, 0, 0, 0, 1, 3, -1);
    add(0, 1, 1, 0, 0, 0, 4, -1);
    add(0, 0, 1, 0, 0, 1, 5, -1);
    add(0, 2, 1, 0, 0, 0, 6, -1);
    add(0, 1, 2, 0, 0, 1, 7, -1);
    add(0, 0, 2, 0, 0, 0, 8, -1);
    add(0, 2, 2, 0, 3, 0, 9, 92761);
    // Win on the ninth cell beats the draw.
    add(1, 0, 0, 0, 0, 1, 1, -1);
    add(0, 1, 0, 0, 0, 0, 2, -1);
    add(0, 2, 0, 0, 0, 1, 3, -1);
    add(0, 1, 1, 0, 0, 0, 4, -1);
    add(0, 0, 2, 0, 0, 1, 5, -1);
    add(0, 2, 2, 0, 0, 0, 6, -1);
    add(0, 1, 2, 0, 0, 1, 7, -1);
    add(0, 2, 1, 0, 0, 0, 8, -1);
    add(0, 0, 1, 0, 1, 0, 9, -1);
    // Top row win for X.
    add(1, 0, 0, 0, 0, 1, 1, -1);
    add(0, 0, 1, 0, 0, 0, 2, -1);
    add(0, 1, 0, 0, 0, 1, 3, -1);
    add(0, 1, 1, 0, 0, 0, 4, -1);
    add(0, 2, 0, 0, 1, 0, 5, 661);

    sel = 1'b0;
    foreach (vq[i]) begin
      if (vq[i].ng) pulse_ng();
      do_move(vq[i].x, vq[i].y, err, lat);
      chk($sformatf("v%0d_err", i), {63'd0, err}, 64'(vq[i].err));
      chk($sformatf("v%0d_lat", i), 64'(lat), vq[i].err ? 64'd0 : 64'(8 * (3 - 1)));
      chk($sformatf("v%0d_win", i), {62'd0, m_win}, 64'(vq[i].win));
      chk($sformatf("v%0d_over", i), {63'd0, m_over}, (vq[i].win != 0) ? 64'd1 : 64'd0);
      chk($sformatf("v%0d_turn", i), {63'd0, m_trn}, 64'(vq[i].trn));
      chk($sformatf("v%0d_cnt", i), {59'd0, m_cnt}, 64'(vq[i].cnt));
      if (vq[i].brd >= 0) chk($sformatf("v%0d_board", i), {46'd0, b3}, 64'(vq[i].brd));
    end

    // Game over: a move presented now is ignored without an error.
    mx = 3'd2; my = 3'd2; v3 = 1'b1;
    @(negedge clk);
    chk("done_err", {63'd0, e3}, 64'd0);
    @(negedge clk);
    v3 = 1'b0;
    chk("done_cnt", {60'd0, c3}, 64'd5);
    chk("done_board", {46'd0, b3}, 64'd661);
    chk("done_ready", {63'd0, r3}, 64'd0);

`ifdef SCOREBOARD_EN
    exp_sx = 2; exp_so = 0; exp_sd = 1;
`else
    exp_sx = 0; exp_so = 0; exp_sd = 0;
`endif
    chk("score_x", {56'd0, sx3}, 64'(exp_sx));
    chk("score_o", {56'd0, so3}, 64'(exp_so));
    chk("score_draw", {56'd0, sd3}, 64'(exp_sd));
    pulse_ng();
    chk("ng_score_draw", {56'd0, sd3}, 64'(exp_sd));
    chk("ng_board", {46'd0, b3}, 64'd0);
    chk("ng_winner", {62'd0, w3}, 64'd0);
    chk("ng_ready", {63'd0, r3}, 64'd1);

    // new_game in the middle of CHECK aborts it.
    mx = 3'd1; my = 3'd1; v3 = 1'b1;
    @(negedge clk);
    v3 = 1'b0;
    chk("mid_busy", {63'd0, r3}, 64'd0);
    repeat (5) @(negedge clk);
    ng3 = 1'b1;
    @(negedge clk);
    ng3 = 1'b0;
    chk("mid_board", {46'd0, b3}, 64'd0);
    chk("mid_winner", {62'd0, w3}, 64'd0);
    chk("mid_turn", {63'd0, t3}, 64'd0);
    chk("mid_ready", {63'd0, r3}, 64'd1);
    chk("mid_cnt", {60'd0, c3}, 64'd0);
    repeat (20) @(negedge clk);
    chk("mid_late_turn", {63'd0, t3}, 64'd0);
    chk("mid_late_over", {63'd0, over3}, 64'd0);

    // A move together with new_game is dropped silently.
    mx = 3'd0; my = 3'd0; v3 = 1'b1; ng3 = 1'b1;
    @(negedge clk);
    v3 = 1'b0; ng3 = 1'b0;
    chk("ngmv_err", {63'd0, e3}, 64'd0);
    chk("ngmv_cnt", {60'd0, c3}, 64'd0);
    chk("ngmv_board", {46'd0, b3}, 64'd0);
    chk("ngmv_ready", {63'd0, r3}, 64'd1);

    // 5x5, four in a row: O on the anti-diagonal; X's three-in-a-row is not enough.
    sel = 1'b1;
    pulse_ng();
    for (int i = 0; i < 7; i++) begin
      do_move(xs5[i], ys5[i], err, lat);
      chk($sformatf("n5_m%0d_lat", i), 64'(lat), 64'd24);
    end
    chk("n5_nowin_yet", {62'd0, w5}, 64'd0);
    do_move(xs5[7], ys5[7], err, lat);
    chk("n5_err", {63'd0, err}, 64'd0);
    chk("n5_lat", 64'(lat), 64'd24);
    chk("n5_winner", {62'd0, w5}, 64'd2);
    chk("n5_over", {63'd0, over5}, 64'd1);
    chk("n5_turn", {63'd0, t5}, 64'd1);
    chk("n5_cnt", {59'd0, c5}, 64'd8);
    chk("n5_ready", {63'd0, r5}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
